// File: rtl/axi4_lite_master.sv
// axi4_lite_master
//   Single-outstanding AXI4-Lite initiator. A user command (read or write) is
//   accepted only in IDLE. It becomes one AXI4-Lite transaction, and the
//   slave's data/response is held on RSP_* until the user takes it.
// Ports
//   ACLK, ARESETN                    clock, async active-low reset
//   CMD_VALID/READY/WRITE/ADDR/WDATA/WSTRB   user command channel
//   RSP_VALID/READY/WRITE/RDATA/RESP         user response channel
//   M_AW*, M_W*, M_B*, M_AR*, M_R*            AXI4-Lite master channels
module axi4_lite_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic                      CMD_WRITE,
  input  logic [ADDRESS_WIDTH-1:0]  CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]     CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   CMD_WSTRB,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic                      RSP_WRITE,
  output logic [DATA_WIDTH-1:0]     RSP_RDATA,
  output logic [1:0]                RSP_RESP,
  output logic [ADDRESS_WIDTH-1:0]  M_AWADDR,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  output logic [ADDRESS_WIDTH-1:0]  M_ARADDR,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RVALID,
  output logic                      M_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

  state_t                      state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [DATA_WIDTH/8-1:0]     wstrb_q;
  logic                        awvalid_q, wvalid_q, arvalid_q;
  logic                        aw_done_q, w_done_q;
  logic                        cmd_fire, aw_hs, w_hs, ar_hs;

  assign CMD_READY = (state_q == IDLE);
  assign RSP_VALID = (state_q == RESP);
  assign M_BREADY  = (state_q == WR_RESP);
  assign M_RREADY  = (state_q == RD_DATA);
  assign M_AWVALID = awvalid_q;
  assign M_WVALID  = wvalid_q;
  assign M_ARVALID = arvalid_q;
  assign M_AWADDR  = addr_q;
  assign M_ARADDR  = addr_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;

  assign cmd_fire = CMD_VALID && CMD_READY;
  assign aw_hs    = awvalid_q && M_AWREADY;
  assign w_hs     = wvalid_q && M_WREADY;
  assign ar_hs    = arvalid_q && M_ARREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = CMD_WRITE ? WR_REQ : RD_ADDR;
      // A channel counts as done if it completed earlier or completes now,
      // so AW and W handshaking on the same edge leaves in one step.
      WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      WR_RESP: if (M_BVALID) state_d = RESP;
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (M_RVALID) state_d = RESP;
      RESP:    if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      RSP_WRITE <= 1'b0;
      RSP_RDATA <= '0;
      RSP_RESP  <= 2'b00;
    end else begin
      if (cmd_fire) begin
        addr_q    <= CMD_ADDR;
        wdata_q   <= CMD_WDATA;
        wstrb_q   <= CMD_WSTRB;
        awvalid_q <= CMD_WRITE;
        wvalid_q  <= CMD_WRITE;
        arvalid_q <= !CMD_WRITE;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      // Each write channel retires independently; the other keeps VALID up.
      if (aw_hs) begin
        awvalid_q <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        wvalid_q <= 1'b0;
        w_done_q <= 1'b1;
      end
      if (ar_hs) arvalid_q <= 1'b0;
      if (state_q == WR_RESP && M_BVALID) begin
        RSP_WRITE <= 1'b1;
        RSP_RDATA <= '0;
        RSP_RESP  <= M_BRESP;
      end
      if (state_q == RD_DATA && M_RVALID) begin
        RSP_WRITE <= 1'b0;
        RSP_RDATA <= M_RDATA;
        RSP_RESP  <= M_RRESP;
      end
    end
  end

endmodule
